regfile_wr_arbiter: RTL

//  Sequences the single write port of the 32x32 register file. Two writeback sources
//   (A = ALU, B = load unit) share the port under round-robin arbitration.

---
 rtl/regfile_wr_arbiter_pkg.sv | 18 +
 rtl/regfile_wr_arbiter_if.sv | 12 +
 rtl/regfile_wr_arbiter_rr_arb2.sv | 42 ++++
 rtl/regfile_wr_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and encodings for the register-file write arbiter.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;
  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  // r0 is hardwired zero in the register file, so writes to it are suppressed
  function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_ZERO);
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Valid/ready writeback channel from one source into the write arbiter.
interface regfile_wr_arbiter_if;
  import regfile_pkg::*;

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves to the loser after every grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  prio_e prio_r;

  // Grant decode: a lone request always wins, a conflict goes to the priority holder
  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio_r == PRIO_A) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Priority pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= PRIO_A;
    end else if (gnt[0]) begin
      prio_r <= PRIO_B;
    end else if (gnt[1]) begin
      prio_r <= PRIO_A;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port sequencer: post-reset clear of r1..NUM_REGS-1, then
// round-robin arbitration between ALU (a) and load unit (b) writebacks.
module regfile_wr_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                        elk,
  input  logic                        nrst,
  regfile_wr_arbiter_if.slave         a,
  regfile_wr_arbiter_if.slave         b,
  output logic                        wr_en,
  output logic [regfile_pkg::ADDR_W-1:0] wr_addr,
  output logic [regfile_pkg::DATA_W-1:0] wr_data,
  output logic                        init_done
);
  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(NUM_REGS - 1);
  localparam logic              INIT_ON  = (INIT_CLEAR != 0);

  state_e            state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [1:0]        gnt_s;
  logic              acc_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_data_s;

  rr_arb2 u_arb (
    .clk     (elk),
    .rst     (nrst),
    .req     ({b.valid, a.valid}),
    .advance (state_r == S_RUN),
    .gnt     (gnt_s)
  );

  assign a.ready = gnt_s[0];
  assign b.ready = gnt_s[1];

  // Select the accepted source's write
  always_comb begin
    acc_s      = 1'b0;
    acc_addr_s = ADDR_ZERO;
    acc_data_s = DATA_ZERO;
    if (gnt_s[0]) begin
      acc_s      = 1'b1;
      acc_addr_s = a.addr;
      acc_data_s = a.data;
    end else if (gnt_s[1]) begin
      acc_s      = 1'b1;
      acc_addr_s = b.addr;
      acc_data_s = b.data;
    end else begin
      acc_s      = 1'b0;
    end
  end

  // Sequencer FSM and registered write port
  always_ff @(posedge elk) begin
    if (nrst) begin
      wr_en     <= 1'b0;
      wr_addr   <= ADDR_ZERO;
      wr_data   <= DATA_ZERO;
      clr_cnt_r <= ADDR_ONE;
      state_r   <= INIT_ON ? S_INIT : S_RUN;
      init_done <= ~INIT_ON;
    end else begin
      case (state_r)
        S_INIT: begin
          wr_en     <= 1'b1;
          wr_addr   <= clr_cnt_r;
          wr_data   <= DATA_ZERO;
          clr_cnt_r <= clr_cnt_r + ADDR_ONE;
          init_done <= 1'b0;
          state_r   <= (clr_cnt_r == LAST_CLR) ? S_RUN : S_INIT;
        end
        S_RUN: begin
          init_done <= 1'b1;
          state_r   <= S_RUN;
          // r0 accepts still load address/data; only the enable is suppressed
          wr_en     <= acc_s && !is_r0(acc_addr_s);
          if (acc_s) begin
            wr_addr <= acc_addr_s;
            wr_data <= acc_data_s;
          end else begin
            wr_addr <= wr_addr;
            wr_data <= wr_data;
          end
        end
        default: begin
          wr_en     <= 1'b0;
          clr_cnt_r <= ADDR_ONE;
          init_done <= 1'b0;
          state_r   <= S_INIT;
        end
      endcase
    end
  end

endmodule
